decode_stage_p: RTL and testbench

DECODE_STAGE_P -- requirements
Module: decode_stage_p

---
 rtl/decode_stage_p_if.sv | 56 +++++
 rtl/decode_stage_p.sv | 162 ++++++++++++++++
 tb/tb_decode_stage_p.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_p_if.sv
// Decode-stage bus: fetch/control-side instruction inputs, writeback port,
// stall back-pressure and the registered EX-stage operand bundle.
interface decode_stage_p_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 24
);
    logic              in_valid;
    logic [15:0]       instr;
    logic [DATA_W-1:0] pc;
    logic [CTRL_W-1:0] ctrl_in;
    logic [1:0]        reg_dst;
    logic              reg_write;
    logic              mem_read;
    logic              use_rs;
    logic              use_rt;
    logic              ctrl_halt;
    logic [1:0]        imm_sel;
    logic              imm_sext;
    logic              wb_write;
    logic [2:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              flush;

    logic              stall;

    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_halt;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [2:0]        ex_rs;
    logic [2:0]        ex_rt;
    logic [2:0]        ex_wreg;

    modport master (
        output in_valid, instr, pc, ctrl_in, reg_dst, reg_write, mem_read,
               use_rs, use_rt, ctrl_halt, imm_sel, imm_sext,
               wb_write, wb_reg, wb_data, flush,
        input  stall,
               ex_valid, ex_reg_write, ex_mem_read, ex_halt,
               ex_rd1, ex_rd2, ex_imm, ex_pc, ex_ctrl, ex_rs, ex_rt, ex_wreg
    );

    modport slave (
        input  in_valid, instr, pc, ctrl_in, reg_dst, reg_write, mem_read,
               use_rs, use_rt, ctrl_halt, imm_sel, imm_sext,
               wb_write, wb_reg, wb_data, flush,
        output stall,
               ex_valid, ex_reg_write, ex_mem_read, ex_halt,
               ex_rd1, ex_rd2, ex_imm, ex_pc, ex_ctrl, ex_rs, ex_rt, ex_wreg
    );
endinterface

// File: rtl/decode_stage_p.sv
// Decode stage: register file with write bypass, immediate generation,
// load-use hazard stall, sticky halt and the ID/EX pipeline register.
module decode_stage_p #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 24,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    decode_stage_p_if.slave  bus,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);
    localparam int unsigned NREG  = 8;
    localparam int unsigned REG_W = 3;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              halt;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  wreg;
    } ex_t;

    state_t            state_q, state_d;
    ex_t               ex_q, ex_d;
    logic [DATA_W-1:0] rf [NREG];

    logic [REG_W-1:0]  rs, rt, wreg_c;
    logic [DATA_W-1:0] rd1_c, rd2_c, imm_c;
    logic              first_c, hazard_c, stall_c, accept_c;
    logic              unused_instr_hi;

    assign rs              = bus.instr[10:8];
    assign rt              = bus.instr[7:5];
    assign unused_instr_hi = ^bus.instr[15:11];

    // Register file; writes continue while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_write) begin
            rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    // Same-cycle writeback is forwarded so decode never sees a stale value.
    assign rd1_c = (bus.wb_write && (bus.wb_reg == rs)) ? bus.wb_data : rf[rs];
    assign rd2_c = (bus.wb_write && (bus.wb_reg == rt)) ? bus.wb_data : rf[rt];

    always_comb begin
        imm_c = '0;
        case (bus.imm_sel)
            2'b00:   imm_c = {{(DATA_W-11){bus.instr[10]}}, bus.instr[10:0]};
            2'b01:   imm_c = {{(DATA_W-5){bus.imm_sext & bus.instr[4]}}, bus.instr[4:0]};
            2'b10:   imm_c = {{(DATA_W-8){bus.instr[7]}}, bus.instr[7:0]};
            default: imm_c = '0;
        endcase
    end

    always_comb begin
        wreg_c = '0;
        case (bus.reg_dst)
            2'b00:   wreg_c = bus.instr[4:2];
            2'b01:   wreg_c = REG_W'(7);
            2'b10:   wreg_c = bus.instr[10:8];
            default: wreg_c = bus.instr[7:5];
        endcase
    end

    assign first_c  = (state_q == ST_FIRST);
    assign halted   = (state_q == ST_HALT);
    assign hazard_c = bus.in_valid & ex_q.valid & ex_q.mem_read & ex_q.reg_write &
                      ((bus.use_rs & (ex_q.wreg == rs)) | (bus.use_rt & (ex_q.wreg == rt)));
    assign stall_c  = hazard_c & ~bus.flush & ~halted;
    assign accept_c = bus.in_valid & ~bus.flush & ~stall_c & ~halted;
    assign err      = bus.in_valid & (bus.imm_sel == 2'b11) & ~halted;
    assign bus.stall = stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt is ignored for the single cycle following reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FIRST: state_d = ST_RUN;
            ST_RUN:   if (accept_c && bus.ctrl_halt) state_d = ST_HALT;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FIRST;
        endcase
    end

    always_comb begin
        ex_d = '0;
        if (accept_c) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = bus.reg_write;
            ex_d.mem_read  = bus.mem_read;
            ex_d.halt      = bus.ctrl_halt & ~first_c;
            ex_d.rd1       = rd1_c;
            ex_d.rd2       = rd2_c;
            ex_d.imm       = imm_c;
            ex_d.pc        = bus.pc;
            ex_d.ctrl      = bus.ctrl_in;
            ex_d.rs        = rs;
            ex_d.rt        = rt;
            ex_d.wreg      = wreg_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_halt      = ex_q.halt;
    assign bus.ex_rd1       = ex_q.rd1;
    assign bus.ex_rd2       = ex_q.rd2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_wreg      = ex_q.wreg;
endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p: expected EX bundles are queued when an
// instruction is driven and compared one edge later.
module tb_decode_stage_p;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CTRL_W = 24;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              halt;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [CTRL_W-1:0] ctrl;
        logic [2:0]        rs;
        logic [2:0]        rt;
        logic [2:0]        wreg;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;
    int               checks = 0;
    int               errors = 0;
    exp_t             sb[$];

    decode_stage_p_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    decode_stage_p #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t observe();
        exp_t o;
        o.valid = bus.ex_valid;   o.reg_write = bus.ex_reg_write;
        o.mem_read = bus.ex_mem_read; o.halt = bus.ex_halt;
        o.rd1 = bus.ex_rd1; o.rd2 = bus.ex_rd2; o.imm = bus.ex_imm; o.pc = bus.ex_pc;
        o.ctrl = bus.ex_ctrl; o.rs = bus.ex_rs; o.rt = bus.ex_rt; o.wreg = bus.ex_wreg;
        return o;
    endfunction

    function automatic exp_t mk(input logic rw, input logic mr, input logic hlt,
                                input logic [DATA_W-1:0] rd1, input logic [DATA_W-1:0] rd2,
                                input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pcv,
                                input logic [CTRL_W-1:0] c, input logic [2:0] rs,
                                input logic [2:0] rt, input logic [2:0] wreg);
        exp_t e;
        e.valid = 1'b1; e.reg_write = rw; e.mem_read = mr; e.halt = hlt;
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.pc = pcv; e.ctrl = c;
        e.rs = rs; e.rt = rt; e.wreg = wreg;
        return e;
    endfunction

    task automatic clear_inputs();
        bus.in_valid = 0; bus.instr = '0; bus.pc = '0; bus.ctrl_in = '0; bus.reg_dst = '0;
        bus.reg_write = 0; bus.mem_read = 0; bus.use_rs = 0; bus.use_rt = 0; bus.ctrl_halt = 0;
        bus.imm_sel = '0; bus.imm_sext = 0; bus.wb_write = 0; bus.wb_reg = '0; bus.wb_data = '0;
        bus.flush = 0;
    endtask

    task automatic set_instr(input logic v, input logic [15:0] ins, input logic [DATA_W-1:0] pcv,
                             input logic [CTRL_W-1:0] c, input logic [1:0] rdst, input logic rw,
                             input logic mr, input logic urs, input logic urt, input logic hlt,
                             input logic [1:0] isel, input logic isx);
        bus.in_valid = v; bus.instr = ins; bus.pc = pcv; bus.ctrl_in = c; bus.reg_dst = rdst;
        bus.reg_write = rw; bus.mem_read = mr; bus.use_rs = urs; bus.use_rt = urt;
        bus.ctrl_halt = hlt; bus.imm_sel = isel; bus.imm_sext = isx;
    endtask

    // Leaves the bench just after the last reset edge, i.e. inside the first cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        repeat (2) @(posedge clk);
        #1;
        got = observe();
        checks++; if (got !== '0) begin errors++; $display("FAIL reset_ex: got %h expected 0", got); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        rst = 1'b0;
        @(negedge clk);
        set_instr(1, 16'h0008, 16'h0010, 24'h000111, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0);
        @(posedge clk); #1;
        @(negedge clk);
        set_instr(1, 16'h0200, 16'h0012, 24'h000222, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0);
        rst = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL reset_hazard_seen: got %b expected 1", bus.stall); end
        @(posedge clk); #1;
        got = observe();
        checks++; if (got !== '0) begin errors++; $display("FAIL reset_mid_stall_ex: got %h expected 0", got); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_mid_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_regfile();
        logic [15:0]       ins  [4] = '{16'h0000, 16'h03A0, 16'h03A0, 16'h07A0};
        logic              wbw  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]        wbr  [4] = '{3'd3, 3'd0, 3'd5, 3'd7};
        logic [DATA_W-1:0] wbd  [4] = '{16'h1234, 16'h0000, 16'hBEEF, 16'h0100};
        logic [1:0]        isel [4] = '{2'b00, 2'b10, 2'b00, 2'b01};
        logic [1:0]        rdst [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic [DATA_W-1:0] e_rd1[4] = '{16'h0000, 16'h1234, 16'h1234, 16'h0100};
        logic [DATA_W-1:0] e_rd2[4] = '{16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF};
        logic [DATA_W-1:0] e_imm[4] = '{16'h0000, 16'hFFA0, 16'h03A0, 16'h0000};
        logic [2:0]        e_rs [4] = '{3'd0, 3'd3, 3'd3, 3'd7};
        logic [2:0]        e_wr [4] = '{3'd0, 3'd0, 3'd7, 3'd7};
        exp_t got, exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_instr(i != 0, ins[i], 16'h0040 + 16'(2 * i), 24'h00A000 + 24'(i), rdst[i],
                      1, 0, 0, 0, 0, isel[i], 1);
            bus.wb_write = wbw[i]; bus.wb_reg = wbr[i]; bus.wb_data = wbd[i];
            if (i == 0) sb.push_back('0);
            else sb.push_back(mk(1, 0, 0, e_rd1[i], e_rd2[i], e_imm[i], 16'h0040 + 16'(2 * i),
                                 24'h00A000 + 24'(i), e_rs[i], 3'd5, e_wr[i]));
            @(posedge clk); #1;
            got = observe(); exp = sb.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL regfile_ex[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_load_use();
        exp_t got, exp;
        do_reset();
        @(negedge clk);
        set_instr(1, 16'h0008, 16'h0010, 24'h000111, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0);
        sb.push_back(mk(1, 1, 0, 16'h0, 16'h0, 16'h0008, 16'h0010, 24'h000111, 3'd0, 3'd0, 3'd2));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL load_issue: got %h expected %h", got, exp); end
        @(negedge clk);
        set_instr(1, 16'h0200, 16'h0012, 24'h000222, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0);
        bus.wb_write = 1; bus.wb_reg = 3'd2; bus.wb_data = 16'h5555;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", bus.stall); end
        sb.push_back('0);
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL load_use_bubble: got %h expected %h", got, exp); end
        checks++; if (stall_cnt !== CNT_W'(1)) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
        @(negedge clk);
        bus.wb_write = 0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_released: got %b expected 0", bus.stall); end
        sb.push_back(mk(1, 0, 0, 16'h5555, 16'h0, 16'h0200, 16'h0012, 24'h000222, 3'd2, 3'd0, 3'd0));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL dependent_issue: got %h expected %h", got, exp); end
        checks++; if (stall_cnt !== CNT_W'(1)) begin errors++; $display("FAIL dependent_cnt: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_flush();
        exp_t got, exp;
        do_reset();
        @(negedge clk);
        set_instr(1, 16'h0008, 16'h0010, 24'h000111, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0);
        @(posedge clk); #1;
        @(negedge clk);
        set_instr(1, 16'h0200, 16'h0012, 24'h000222, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0);
        bus.flush = 1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
        sb.push_back('0);
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL flush_bubble: got %h expected %h", got, exp); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", stall_cnt); end
        bus.flush = 0;
    endtask

    task automatic test_imm();
        logic [15:0]       ins  [5] = '{16'h0150, 16'h0150, 16'h0150, 16'h0450, 16'h0150};
        logic [1:0]        isel [5] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b10};
        logic              isx  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [DATA_W-1:0] e_imm[5] = '{16'hFFF0, 16'h0010, 16'h0000, 16'hFC50, 16'h0050};
        logic              e_err[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]        e_rs [5] = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd1};
        exp_t got, exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_instr(1, ins[i], 16'h0100 + 16'(i), 24'hC0FFEE, 2'b11, 1, 0, 0, 0, 0, isel[i], isx[i]);
            #1;
            checks++; if (err !== e_err[i]) begin errors++; $display("FAIL imm_err[%0d]: got %b expected %b", i, err, e_err[i]); end
            sb.push_back(mk(1, 0, 0, 16'h0, 16'h0, e_imm[i], 16'h0100 + 16'(i), 24'hC0FFEE, e_rs[i], 3'd2, 3'd2));
            @(posedge clk); #1;
            got = observe(); exp = sb.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL imm_ex[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_stall_sat();
        int               nstall = 0;
        logic             exp_stall;
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            set_instr(1, 16'h0208, 16'h0200, 24'h0, 2'b00, 1, 1, 1, 0, 0, 2'b00, 0);
            #1;
            exp_stall = ((i % 2) == 1);
            checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL sat_stall[%0d]: got %b expected %b", i, bus.stall, exp_stall); end
            if (exp_stall) nstall++;
            @(posedge clk); #1;
            exp_cnt = (nstall >= int'(CNT_MAX)) ? CNT_MAX : CNT_W'(nstall);
            checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, stall_cnt, exp_cnt); end
        end
        checks++; if (stall_cnt !== CNT_MAX) begin errors++; $display("FAIL sat_final: got %0d expected %0d", stall_cnt, CNT_MAX); end
    endtask

    task automatic test_halt();
        exp_t got, exp;
        do_reset();
        @(negedge clk);
        set_instr(1, 16'h0100, 16'h0002, 24'h0000F1, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0);
        sb.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0100, 16'h0002, 24'h0000F1, 3'd1, 3'd0, 3'd0));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL halt_first_ex: got %h expected %h", got, exp); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_first_ignored: got %b expected 0", halted); end
        @(negedge clk);
        set_instr(1, 16'h0100, 16'h0004, 24'h0000F2, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0);
        sb.push_back(mk(0, 0, 1, 16'h0, 16'h0, 16'h0100, 16'h0004, 24'h0000F2, 3'd1, 3'd0, 3'd0));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL halt_ex: got %h expected %h", got, exp); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halted); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_instr(1, 16'h0150, 16'h0006, 24'h0000F3, 2'b00, 1, 0, 1, 0, 0, 2'b11, 0);
            bus.wb_write = 1; bus.wb_reg = 3'd4; bus.wb_data = 16'h7777;
            #1;
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL halted_stall[%0d]: got %b expected 0", i, bus.stall); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL halted_err[%0d]: got %b expected 0", i, err); end
            sb.push_back('0);
            @(posedge clk); #1;
            got = observe(); exp = sb.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL halted_bubble[%0d]: got %h expected %h", i, got, exp); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_sticky[%0d]: got %b expected 1", i, halted); end
        end
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_cleared: got %b expected 0", halted); end
        @(negedge clk);
        set_instr(1, 16'h0100, 16'h0008, 24'h0000F4, 2'b01, 1, 0, 0, 0, 0, 2'b00, 0);
        sb.push_back(mk(1, 0, 0, 16'h0, 16'h0, 16'h0100, 16'h0008, 24'h0000F4, 3'd1, 3'd0, 3'd7));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL post_halt_issue: got %h expected %h", got, exp); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_regfile();
        test_load_use();
        test_flush();
        test_imm();
        test_stall_sat();
        test_halt();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
